df_fetch: RTL and testbench

Data-fetch sequencer for the neuron datapath. On a start command it reads `len` input/weight operand pairs from two synchronous single-port memories and streams them, one pair per cycle, to the multiply stage. It is the producer side of the `df_rdy` valid-strobe interface, so it drives `df_rdy` and the operand words. It signals completion so the neuron controller can close the accumulation.

---
 rtl/df_fetch_pkg.sv | 23 ++
 rtl/df_fetch_addr_gen.sv | 67 ++++++
 rtl/df_fetch.sv | 130 +++++++++++++
 tb/tb_df_fetch.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/df_fetch_pkg.sv
// rtl/df_fetch_pkg.sv - shared word/strobe/state definitions and FSM state type for df_fetch
`ifndef DF_FETCH_STDDEF
`define DF_FETCH_STDDEF
`define DATA_WIDTH  32
`define WordDataBus `DATA_WIDTH-1:0
`define ENABLE      1'b1
`define DISABLE     1'b0
`define DF_ST_IDLE  2'd0
`define DF_ST_FETCH 2'd1
`define DF_ST_DRAIN 2'd2
`define DF_ST_DONE  2'd3
`endif

package df_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `DF_ST_IDLE,
    ST_FETCH = `DF_ST_FETCH,
    ST_DRAIN = `DF_ST_DRAIN,
    ST_DONE  = `DF_ST_DONE
  } df_state_e;

endpackage

// File: rtl/df_fetch_addr_gen.sv
// rtl/df_fetch_addr_gen.sv - pair index counter, wrapping base+index addresses, last-read flag (DF_BIAS_EN adds the bias read)
module df_addr_gen
  import df_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ADDR_WIDTH-1:0] x_base_i,
  input  logic [ADDR_WIDTH-1:0] w_base_i,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic                  last_o
);

  logic [LEN_WIDTH-1:0]  i_q, i_d;
  logic [LEN_WIDTH-1:0]  last_idx_q, last_idx_d;
  logic [ADDR_WIDTH-1:0] x_base_q, x_base_d;
  logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;

  // Index of the final read: the bias read sits one past the operand pairs.
  // Without bias a zero length never reaches FETCH, so the wrap of len-1 is harmless.
  always_comb begin
`ifdef DF_BIAS_EN
    last_idx_d = len_i;
`else
    last_idx_d = len_i - LEN_WIDTH'(1);
`endif
    i_d      = i_q;
    x_base_d = x_base_q;
    w_base_d = w_base_q;
    if (load_i) begin
      i_d      = '0;
      x_base_d = x_base_i;
      w_base_d = w_base_i;
    end else begin
      last_idx_d = last_idx_q;
      if (adv_i) begin
        i_d = i_q + LEN_WIDTH'(1);
      end
    end
  end

  // Command latch and index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q        <= '0;
      last_idx_q <= '0;
      x_base_q   <= '0;
      w_base_q   <= '0;
    end else begin
      i_q        <= i_d;
      last_idx_q <= last_idx_d;
      x_base_q   <= x_base_d;
      w_base_q   <= w_base_d;
    end
  end

  assign x_addr_o = x_base_q + ADDR_WIDTH'(i_q);
  assign w_addr_o = w_base_q + ADDR_WIDTH'(i_q);
  assign last_o   = (i_q == last_idx_q);

endmodule

// File: rtl/df_fetch.sv
// rtl/df_fetch.sv - operand-pair fetch sequencer feeding the multiply stage; DF_BIAS_EN appends a bias pair
module df_fetch
  import df_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [ADDR_WIDTH-1:0] w_base,
  output logic                  x_rd,
  output logic                  w_rd,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] x_rdata,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  output logic [DATA_WIDTH-1:0] df_x,
  output logic [DATA_WIDTH-1:0] df_w,
  output logic                  df_rdy,
  output logic                  df_last,
  output logic                  busy,
  output logic                  done
);

  df_state_e state_q, state_d;
  logic      load, adv, last, fetch, len_zero, bias_rd;
  logic      rd_pend_q, last_pend_q;
  logic      df_rdy_q, df_last_q;
  logic [DATA_WIDTH-1:0] df_x_q, df_w_q;

  df_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load),
    .adv_i    (adv),
    .len_i    (len),
    .x_base_i (x_base),
    .w_base_i (w_base),
    .x_addr_o (x_addr),
    .w_addr_o (w_addr),
    .last_o   (last)
  );

`ifdef DF_BIAS_EN
  assign len_zero = 1'b0;
  assign bias_rd  = last;
`else
  assign len_zero = (len == '0);
  assign bias_rd  = 1'b0;
`endif

  // Next state; DRAIN holds until the final pair has left the output register.
  always_comb begin
    state_d = state_q;
    load    = `DISABLE;
    adv     = `DISABLE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = `ENABLE;
          state_d = len_zero ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        adv = ~last;
        if (last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (df_last_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign fetch = (state_q == ST_FETCH);

  // Read-latency tracker and output register; operands read as zero when no pair is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      df_rdy_q    <= 1'b0;
      df_last_q   <= 1'b0;
      df_x_q      <= '0;
      df_w_q      <= '0;
    end else begin
      rd_pend_q   <= fetch;
      last_pend_q <= fetch & last;
      df_rdy_q    <= rd_pend_q;
      df_last_q   <= last_pend_q;
      df_w_q      <= rd_pend_q ? w_rdata : '0;
`ifdef DF_BIAS_EN
      df_x_q      <= rd_pend_q ? (last_pend_q ? DATA_WIDTH'(1) : x_rdata) : '0;
`else
      df_x_q      <= rd_pend_q ? x_rdata : '0;
`endif
    end
  end

  assign x_rd    = fetch & ~bias_rd;
  assign w_rd    = fetch;
  assign df_x    = df_x_q;
  assign df_w    = df_w_q;
  assign df_rdy  = df_rdy_q;
  assign df_last = df_last_q;
  assign busy    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_df_fetch.sv
// tb/tb_df_fetch.sv - directed self-checking bench for df_fetch
module tb_df_fetch;

`ifdef DF_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [7:0]  x_base = '0;
  logic [7:0]  w_base = '0;
  logic        x_rd, w_rd;
  logic [7:0]  x_addr, w_addr;
  logic [31:0] x_rdata = '0;
  logic [31:0] w_rdata = '0;
  logic [31:0] df_x, df_w;
  logic        df_rdy, df_last, busy, done;

  logic [31:0] x_mem [256];
  logic [31:0] w_mem [256];

  int n_checks = 0;
  int n_err = 0;

  df_fetch dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .x_base  (x_base),
    .w_base  (w_base),
    .x_rd    (x_rd),
    .w_rd    (w_rd),
    .x_addr  (x_addr),
    .w_addr  (w_addr),
    .x_rdata (x_rdata),
    .w_rdata (w_rdata),
    .df_x    (df_x),
    .df_w    (df_w),
    .df_rdy  (df_rdy),
    .df_last (df_last),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memories, one cycle read latency.
  always @(posedge clk) begin
    if (x_rd) x_rdata <= x_mem[x_addr];
    if (w_rd) w_rdata <= w_mem[w_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string tg(input string s, input int c);
    return $sformatf("%s@c%0d", s, c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".x_rd"},    32'(x_rd),    32'd0);
    chk({tag, ".w_rd"},    32'(w_rd),    32'd0);
    chk({tag, ".x_addr"},  32'(x_addr),  32'd0);
    chk({tag, ".w_addr"},  32'(w_addr),  32'd0);
    chk({tag, ".df_x"},    df_x,         32'd0);
    chk({tag, ".df_w"},    df_w,         32'd0);
    chk({tag, ".df_rdy"},  32'(df_rdy),  32'd0);
    chk({tag, ".df_last"}, 32'(df_last), 32'd0);
    chk({tag, ".busy"},    32'(busy),    32'd0);
    chk({tag, ".done"},    32'(done),    32'd0);
  endtask

  // One command; start is cycle 0. Optional stray start and mid-run reset.
  task automatic run(input string nm, input int len_v, input int xb, input int wb,
                     input int restart_at, input int reset_at);
    int n, pairs, dones, p, done_c;
    logic [31:0] ex, ew;
    bit fetch_e, rdy_e, last_e, bias_c;
    n = len_v + BIAS;
    done_c = (n == 0) ? 1 : n + 3;
    len = 8'(len_v);
    x_base = 8'(xb);
    w_base = 8'(wb);
    start = 1'b1;
    tick();
    start = 1'b0;
    pairs = 0;
    dones = 0;
    for (int c = 1; c <= n + 4; c++) begin
      fetch_e = (c <= n);
      bias_c  = (BIAS == 1) && (c == n);
      rdy_e   = (n > 0) && (c >= 3) && (c <= n + 2);
      last_e  = (n > 0) && (c == n + 2);
      p = c - 3;
      chk(tg({nm, ".w_rd"}, c), 32'(w_rd), 32'(fetch_e));
      chk(tg({nm, ".x_rd"}, c), 32'(x_rd), 32'(fetch_e && !bias_c));
      if (fetch_e) begin
        chk(tg({nm, ".w_addr"}, c), 32'(w_addr), (wb + c - 1) & 255);
        if (!bias_c) chk(tg({nm, ".x_addr"}, c), 32'(x_addr), (xb + c - 1) & 255);
      end
      if (rdy_e) begin
        ex = ((BIAS == 1) && (p == n - 1)) ? 32'd1 : x_mem[(xb + p) & 255];
        ew = w_mem[(wb + p) & 255];
      end else begin
        ex = '0;
        ew = '0;
      end
      chk(tg({nm, ".df_rdy"}, c),  32'(df_rdy),  32'(rdy_e));
      chk(tg({nm, ".df_last"}, c), 32'(df_last), 32'(last_e));
      chk(tg({nm, ".df_x"}, c), df_x, ex);
      chk(tg({nm, ".df_w"}, c), df_w, ew);
      chk(tg({nm, ".busy"}, c), 32'(busy), 32'((n > 0) && (c <= n + 2)));
      chk(tg({nm, ".done"}, c), 32'(done), 32'(c == done_c));
      if (df_rdy) pairs++;
      if (done) dones++;
      if (c == reset_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero(tg({nm, ".after_reset"}, c + 1));
        return;
      end
      start = (c == restart_at);
      if (start) begin
        len = 8'd1;
        x_base = 8'h00;
        w_base = 8'h00;
      end
      tick();
    end
    start = 1'b0;
    chk({nm, ".pairs"}, pairs, n);
    chk({nm, ".dones"}, dones, 1);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      x_mem[a] = a + 1;
      w_mem[a] = a + 1;
    end
    reset = 1'b1;
    tick();
    tick();
    check_zero("reset_held");
    reset = 1'b0;
    tick();
    check_zero("reset_released");

    run("len4", 4, 'h10, 'h80, 0, 0);
    run("len0", 0, 'h20, 'h30, 0, 0);
    run("wrap", 3, 'hFE, 'h40, 0, 0);
    run("restart", 4, 'h10, 'h80, 2, 0);
    run("midreset", 8, 'h00, 'h90, 0, 4);
    run("post_reset", 2, 'h05, 'h60, 0, 0);
`ifdef DF_BIAS_EN
    w_mem['hA2] = 32'h55;
    run("bias", 2, 'h30, 'hA0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
